// File: rtl/demux8way_pkg.sv
// Shared constants and FSM state type for the 8-way demultiplexing frame collector.
package demux8way_pkg;
    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    localparam logic [NUM_LANES-1:0] MASK_FULL = 8'hFF;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/demux8way_lane_bank.sv
// Eight WIDTH-bit lane registers, each loaded when the decoded select hits it.
module demux8way_lane_bank
    import demux8way_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 wr_en_i,
    input  logic [SEL_W-1:0]                     sel_i,
    input  logic [WIDTH-1:0]                     data_i,
    output logic [NUM_LANES-1:0][WIDTH-1:0]      lanes_o
);

    logic [NUM_LANES-1:0] lane_we;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] lane_q;

        assign lane_we[gi] = wr_en_i && (sel_i == SEL_W'(gi));

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                lane_q <= '0;
            end else if (lane_we[gi]) begin
                lane_q <= data_i;
            end
        end

        assign lanes_o[gi] = lane_q;
    end

endmodule

// File: rtl/demux8way_collector.sv
// Collects beats into eight lanes (swept or addressed) and presents each full
// frame on a valid/ready handshake until it is taken.
module demux8way_collector
    import demux8way_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [WIDTH-1:0]     IN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic                 MODE,
    input  logic [SEL_W-1:0]     SEL,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     E,
    output logic [WIDTH-1:0]     F,
    output logic [WIDTH-1:0]     G,
    output logic [WIDTH-1:0]     H,
    output logic [NUM_LANES-1:0] MASK,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic                 accept;
    logic [SEL_W-1:0]     target;
    logic [NUM_LANES-1:0][WIDTH-1:0] lanes;

    assign accept = IN_VALID && (state_q == FILL);
    assign target = MODE ? cnt_q : SEL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    mask_d = mask_q | (NUM_LANES'(1) << target);
                    if (MODE) begin
                        cnt_d = cnt_q + SEL_W'(1);
                    end
                    if (mask_d == MASK_FULL) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    state_d = FILL;
                    mask_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= FILL;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    demux8way_lane_bank #(
        .WIDTH (WIDTH)
    ) u_lane_bank (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .wr_en_i (accept),
        .sel_i   (target),
        .data_i  (IN),
        .lanes_o (lanes)
    );

    // Handshake flags decode straight from the state register; no input reaches them.
    assign IN_READY  = (state_q == FILL);
    assign OUT_VALID = (state_q == HOLD);
    assign MASK      = mask_q;

    assign A = lanes[0];
    assign B = lanes[1];
    assign C = lanes[2];
    assign D = lanes[3];
    assign E = lanes[4];
    assign F = lanes[5];
    assign G = lanes[6];
    assign H = lanes[7];

endmodule

// File: tb/tb_demux8way_collector.sv
// Directed self-checking bench for demux8way_collector with WIDTH=1.
module tb_demux8way_collector;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [0:0] IN;
    logic       IN_VALID;
    logic       IN_READY;
    logic       MODE;
    logic [2:0] SEL;
    logic [0:0] A, B, C, D, E, F, G, H;
    logic [7:0] MASK;
    logic       OUT_VALID;
    logic       OUT_READY;

    int checks   = 0;
    int failures = 0;

    demux8way_collector #(.WIDTH(1)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE      (MODE),
        .SEL       (SEL),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .E         (E),
        .F         (F),
        .G         (G),
        .H         (H),
        .MASK      (MASK),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] lanes();
        return {A, B, C, D, E, F, G, H};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic m, input logic [2:0] s, input logic d);
        IN_VALID = 1'b1;
        MODE     = m;
        SEL      = s;
        IN       = d;
        tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IN_VALID = 1'b1; IN = 1'b1; MODE = 1'b1; SEL = 3'd0; OUT_READY = 1'b0;
        tick();
        tick();
        checks++;
        if (lanes() !== 8'h00 || MASK !== 8'h00 || OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_state lanes=%h mask=%h out_valid=%b required 00 00 0", lanes(), MASK, OUT_VALID);
        end
        RST_N = 1'b1; IN_VALID = 1'b0;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b required=1", IN_READY);
        end
        $display("reset: lanes=%h mask=%h in_ready=%b", lanes(), MASK, IN_READY);
    endtask

    task automatic test_sweep();
        logic [7:0] bits;
        bits = 8'b10110010;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 3'd7 - 3'(i), bits[7-i]);
            checks++;
            if (OUT_VALID !== (i == 7) || MASK !== (8'hFF >> (7 - i))) begin
                failures++;
                $display("FAIL sweep_beat%0d out_valid=%b mask=%h required %b %h",
                         i, OUT_VALID, MASK, (i == 7), 8'hFF >> (7 - i));
            end
            $display("sweep beat %0d: in=%b mask=%h out_valid=%b", i, bits[7-i], MASK, OUT_VALID);
        end
        IN_VALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (lanes() !== 8'b10110010 || IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
                failures++;
                $display("FAIL sweep_hold%0d lanes=%b in_ready=%b out_valid=%b required 10110010 0 1",
                         c, lanes(), IN_READY, OUT_VALID);
            end
            tick();
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        checks++;
        if (MASK !== 8'h00 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL sweep_release mask=%h in_ready=%b out_valid=%b required 00 1 0", MASK, IN_READY, OUT_VALID);
        end
        $display("sweep release: mask=%h in_ready=%b", MASK, IN_READY);
    endtask

    task automatic test_addressed();
        logic [2:0] sel_tab  [9] = '{3'd7, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        logic       dat_tab  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] mask_tab [9] = '{8'h80, 8'h88, 8'h88, 8'h89, 8'h8B, 8'h8F, 8'h9F, 8'hBF, 8'hFF};
        for (int i = 0; i < 9; i++) begin
            beat(1'b0, sel_tab[i], dat_tab[i]);
            checks++;
            if (MASK !== mask_tab[i] || OUT_VALID !== (i == 8)) begin
                failures++;
                $display("FAIL addr_beat%0d mask=%h out_valid=%b required %h %b",
                         i, MASK, OUT_VALID, mask_tab[i], (i == 8));
            end
            $display("addressed beat %0d: sel=%0d in=%b mask=%h out_valid=%b",
                     i, sel_tab[i], dat_tab[i], MASK, OUT_VALID);
        end
        IN_VALID = 1'b0;
        checks++;
        if (D !== 1'b0 || lanes() !== 8'b11101111) begin
            failures++;
            $display("FAIL addr_lanes lanes=%b D=%b required 11101111 D=0", lanes(), D);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 10; c++) begin
            beat(1'b1, 3'(c), 1'(c));
            checks++;
            if (lanes() !== 8'b11101111 || IN_READY !== 1'b0 || MASK !== 8'hFF || OUT_VALID !== 1'b1) begin
                failures++;
                $display("FAIL backpressure%0d lanes=%b in_ready=%b mask=%h out_valid=%b required 11101111 0 ff 1",
                         c, lanes(), IN_READY, MASK, OUT_VALID);
            end
            $display("backpressure cycle %0d: lanes=%b in_ready=%b", c, lanes(), IN_READY);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        checks++;
        if (IN_READY !== 1'b1 || MASK !== 8'h00) begin
            failures++;
            $display("FAIL backpressure_release in_ready=%b mask=%h required 1 00", IN_READY, MASK);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] bits;
        for (int i = 0; i < 4; i++) beat(1'b1, 3'd0, 1'b1);
        checks++;
        if (MASK !== 8'h0F || lanes() !== 8'b11111111) begin
            failures++;
            $display("FAIL midframe_pre mask=%h lanes=%b required 0f 11111111", MASK, lanes());
        end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1; IN_VALID = 1'b0;
        checks++;
        if (MASK !== 8'h00 || lanes() !== 8'h00 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset mask=%h lanes=%b in_ready=%b out_valid=%b required 00 00000000 1 0",
                     MASK, lanes(), IN_READY, OUT_VALID);
        end
        bits = 8'b01101001;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 3'd5, bits[7-i]);
            checks++;
            if (MASK !== (8'hFF >> (7 - i)) || OUT_VALID !== (i == 7)) begin
                failures++;
                $display("FAIL resweep_beat%0d mask=%h out_valid=%b required %h %b",
                         i, MASK, OUT_VALID, 8'hFF >> (7 - i), (i == 7));
            end
            $display("resweep beat %0d: in=%b mask=%h", i, bits[7-i], MASK);
        end
        IN_VALID = 1'b0;
        checks++;
        if (lanes() !== 8'b01101001) begin
            failures++;
            $display("FAIL resweep_lanes lanes=%b required 01101001", lanes());
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_addressed();
        test_backpressure();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux8way_collector.md
# demux8way_collector

Registered 1-to-8 demultiplexer and frame collector, the receiving end of the 8-to-1 lane multiplexer. Accepts a stream of `WIDTH`-bit beats over a valid/ready handshake and steers each beat into one of eight output lane registers `A`..`H`. In sweep mode an internal counter picks the lane; in addressed mode `SEL` picks it. When all eight lanes of a frame have been written, the frame is presented on a valid/ready output handshake and held stable until accepted.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of each beat and of each output lane.

Ports:
- `CLK`  in  1  sole clock; all logic on the rising edge.
- `RST_N`  in  1  reset, synchronous and active-low.
- `IN`  in  `WIDTH`  beat data.
- `IN_VALID`  in  1  beat present.
- `IN_READY`  out  1  collector accepts a beat this cycle.
- `MODE`  in  1  0 = addressed (lane = `SEL`), 1 = sweep (lane = internal counter).
- `SEL`  in  3  target lane in addressed mode; 0 = `A` … 7 = `H`.
- `A`, `B`, `C`, `D`, `E`, `F`, `G`, `H`  out  `WIDTH` each  registered lane outputs.
- `MASK`  out  8  lanes written in the current frame; bit 0 = `A`.
- `OUT_VALID`  out  1  complete frame held on `A`..`H`.
- `OUT_READY`  in  1  downstream takes the frame.

## Operation
- Accept: `IN_VALID && IN_READY` on a rising edge.
- Two-state FSM, `FILL` and `HOLD`.
- `FILL`:
  - `IN_READY`=1, `OUT_VALID`=0.
  - On accept, target lane := `IN` and `MASK[target]` := 1.
  - Target is `SEL` when `MODE`=0, or the sweep counter when `MODE`=1.
  - In sweep mode the counter increments on each accept and wraps 7→0.
  - When the accept leaves `MASK` = 8'hFF, go to `HOLD`.
- `HOLD`:
  - `IN_READY`=0, `OUT_VALID`=1; `A`..`H` and `MASK` frozen.
  - When `OUT_READY`=1, go to `FILL`, clear `MASK` to 0 and reset the sweep counter to 0.
- Lane registers are never cleared except by reset. The next frame overwrites them lane by lane.
- Addressed-mode rewrite of an already-written lane overwrites the data; `MASK` is unchanged and the frame is not completed early.
- `MODE` is sampled per beat. A mid-frame change is legal: `MASK` persists and the sweep counter keeps its value.
- `SEL` is ignored when `MODE`=1. `IN` and `SEL` are ignored when there is no accept.
- Reset (`RST_N`=0 at an edge), from any state including mid-frame or `HOLD`:
  - state goes to `FILL`;
  - `A`..`H` = 0, `MASK` = 0, sweep counter = 0;
  - `OUT_VALID` = 0, `IN_READY` = 1 on the first cycle after reset.

## Timing
- Accept at edge N: lane value and `MASK` bit are visible after edge N; `IN_READY` is high.
- Completing beat accepted at edge N: `OUT_VALID`=1 and `IN_READY`=0 from edge N, i.e. visible during cycle N+1.
- `OUT_READY` sampled high in `HOLD` at edge M: `OUT_VALID`=0 and `IN_READY`=1 after edge M. No combinational path from `OUT_READY` to `IN_READY`.
- Best-case throughput is 9 cycles per frame: 8 beats plus 1 hold cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Package `demux8way_pkg` holds:
  - `NUM_LANES` = 8 and `SEL_W` = 3;
  - state enum `{FILL, HOLD}`;
  - constant `MASK_FULL` = 8'hFF.
- One sub-module, `demux8way_lane_bank`: a 3-to-8 one-hot decoder plus eight `WIDTH`-bit enable registers with synchronous active-low reset.
- The top level holds the FSM, sweep counter, `MASK` and handshake logic.

## Test plan
- Reset: drive `RST_N`=0 for 2 cycles with `IN_VALID`=1.
  - Require `A`..`H`=0, `MASK`=0, `OUT_VALID`=0, then `IN_READY`=1.
- Sweep, `WIDTH`=1: `MODE`=1, stream bits 1,0,1,1,0,0,1,0 back-to-back, `OUT_READY`=0.
  - Require `OUT_VALID`=1 one cycle after the 8th accept.
  - Require `{A..H}`=8'b10110010 and `IN_READY`=0, stable for 5 cycles.
  - Then pulse `OUT_READY` and require `MASK`=0 and `IN_READY`=1 on the next cycle.
- Addressed, out of order: `MODE`=0, `SEL`=7,3,3,0,1,2,4,5,6 with `IN` = 1 on every beat except 0 on the second `SEL`=3 beat.
  - Require `D`=0.
  - Require `OUT_VALID` only after the 9th accept, with `MASK` going 0x80, 0x88, 0x88, …, 0xFF.
- Backpressure: in `HOLD`, hold `IN_VALID`=1 with changing `IN` for 10 cycles.
  - Require no lane change and `IN_READY`=0 throughout.
- Reset mid-frame: after 4 sweep beats, assert `RST_N`=0 for 1 cycle.
  - Require `MASK`=0 and all lanes 0.
  - A following 8-beat sweep must complete normally, starting at lane `A`.
